// File: rtl/bcd_conv_sched_pkg.sv
// Shared types for the BCD conversion scheduler: FSM state encoding,
// the saturation limit, and the packed {tens,ones} result type.
package bcd_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARB   = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      GAP   = 3'd4
   } state_e;

   // Largest value a two-digit BCD result can hold.
   localparam int BCD_MAX = 99;

   // One result byte: tens digit in [7:4], ones digit in [3:0].
   typedef logic [7:0] bcd_t;

   function automatic bcd_t bcd_pack(input logic [3:0] tens, input logic [3:0] ones);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Bundle between the scheduler, its requesters/display path and the shared
// hex2bcd converter.
//
// Converter handshake: cv_start is a single-cycle pulse; cv_din is valid from
// that cycle and held unchanged until the scheduler samples cv_done high in
// its WAIT state. cv_bcd_h/cv_bcd_l are only looked at in that cycle; cv_done
// at any other time is ignored. There is no back-pressure on the request side:
// req is sampled every cycle and upd is a one-cycle write strobe.
interface bcd_conv_sched_if #(
   parameter int NCH = 3,
   parameter int DW  = 7
);
   import bcd_sched_pkg::*;

   logic [NCH-1:0]    req;
   logic [NCH*DW-1:0] din;
   logic [NCH*8-1:0]  bcd;
   logic [NCH-1:0]    upd;
   logic [NCH-1:0]    sat;
   logic              busy;
   logic              cv_start;
   logic [DW-1:0]     cv_din;
   logic              cv_done;
   logic [3:0]        cv_bcd_h;
   logic [3:0]        cv_bcd_l;
   logic [NCH-1:0]    err;
   state_e            state_dbg;

   // Scheduler side.
   modport slave (
      input  req, din, cv_done, cv_bcd_h, cv_bcd_l,
      output bcd, upd, sat, busy, cv_start, cv_din, err, state_dbg
   );

   // Environment side: requesters, display path and converter.
   modport master (
      output req, din, cv_done, cv_bcd_h, cv_bcd_l,
      input  bcd, upd, sat, busy, cv_start, cv_din, err, state_dbg
   );

endinterface

// File: rtl/bcd_conv_sched_rr_arb.sv
// Round-robin pick among pending channels. The grant is combinational from
// the pending vector and the pointer; the pointer moves past the granted
// channel only when the scheduler accepts the grant (adv_i).
module rr_arb #(
   parameter int NCH = 3,
   parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] pend_i,
   input  logic           adv_i,
   output logic           gnt_vld_o,
   output logic [IW-1:0]  gnt_idx_o
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic          hi_vld, lo_vld;
   logic [IW-1:0] hi_idx, lo_idx;

   // First pending channel at or above the pointer wins, else wrap to the lowest pending one
   always_comb begin
      hi_vld = 1'b0;
      lo_vld = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (pend_i[k]) begin
            lo_vld = 1'b1;
            lo_idx = IW'(k);
            if (IW'(k) >= ptr_q) begin
               hi_vld = 1'b1;
               hi_idx = IW'(k);
            end
         end
      end
      gnt_vld_o = lo_vld;
      gnt_idx_o = hi_vld ? hi_idx : lo_idx;
      ptr_d     = (gnt_idx_o == IW'(NCH - 1)) ? '0 : gnt_idx_o + IW'(1);
   end

   // Pointer register: advance to the channel after the accepted grant
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q <= '0;
      end else if (adv_i) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one hex2bcd converter among NCH requesters.
// Requests are latched per channel, one channel is converted at a time, the
// {tens,ones} result is stored per channel and announced with a one-cycle
// upd strobe. Values above 99 are clamped and flagged in the sticky sat bits.
//
// Optional feature: define CONV_TIMEOUT_EN to abandon a conversion after
// TO_CYC cycles without cv_done and set the sticky err bit of that channel.
// Without it the scheduler waits for cv_done indefinitely and err reads 0.
module bcd_conv_sched
   import bcd_sched_pkg::*;
#(
   parameter int NCH    = 3,
   parameter int DW     = 7,
   parameter int TO_CYC = 64
) (
   input logic              clk,
   input logic              rst,
   bcd_conv_sched_if.slave  bus
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [DW-1:0] MAX_DW = DW'(BCD_MAX);

   if (NCH < 1 || NCH > 8 || DW < 7 || TO_CYC < 1) begin : g_param_check
      $error("bcd_conv_sched: unsupported parameter set");
   end

   state_e            state_q, state_d;
   logic [NCH-1:0]    pend_q, pend_d;
   logic [IW-1:0]     gch_q, gch_d;
   logic [DW-1:0]     cv_din_q, cv_din_d;
   logic [NCH*8-1:0]  bcd_q, bcd_d;
   logic [NCH-1:0]    upd_q, upd_d;
   logic [NCH-1:0]    sat_q, sat_d;

   logic              gnt_vld;
   logic [IW-1:0]     gnt_idx;
   logic [NCH-1:0]    gnt_oh;
   logic [DW-1:0]     din_sel;
   logic              adv;
   logic              conv_ok;
   logic              to_hit;

   // A grant is consumed only in the ARB state
   assign adv     = (state_q == ARB) && gnt_vld;
   assign conv_ok = (state_q == WAIT) && bus.cv_done;

   rr_arb #(
      .NCH (NCH),
      .IW  (IW)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .pend_i    (pend_q),
      .adv_i     (adv),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   // Select the granted channel's operand and build its one-hot mask
   always_comb begin
      din_sel = '0;
      gnt_oh  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gnt_idx == IW'(k)) begin
            din_sel   = bus.din[k*DW +: DW];
            gnt_oh[k] = 1'b1;
         end
      end
   end

   // Scheduler FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|(pend_q | bus.req)) state_d = ARB;
         ARB:     state_d = gnt_vld ? START : IDLE;
         START:   state_d = WAIT;
         WAIT:    if (bus.cv_done || to_hit) state_d = GAP;
         GAP:     state_d = (|(pend_q | bus.req)) ? ARB : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pending set, operand capture, saturation and result write-back
   always_comb begin
      pend_d   = pend_q | bus.req;
      gch_d    = gch_q;
      cv_din_d = cv_din_q;
      sat_d    = sat_q;
      bcd_d    = bcd_q;
      upd_d    = '0;
      if (adv) begin
         // A request arriving in the grant cycle re-arms the channel.
         pend_d = (pend_q & ~gnt_oh) | bus.req;
         gch_d  = gnt_idx;
         if (din_sel > MAX_DW) begin
            cv_din_d = MAX_DW;
            sat_d    = sat_q | gnt_oh;
         end else begin
            cv_din_d = din_sel;
         end
      end
      if (conv_ok) begin
         for (int k = 0; k < NCH; k++) begin
            if (gch_q == IW'(k)) begin
               bcd_d[k*8 +: 8] = bcd_pack(bus.cv_bcd_h, bus.cv_bcd_l);
               upd_d[k]        = 1'b1;
            end
         end
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         pend_q   <= '0;
         gch_q    <= '0;
         cv_din_q <= '0;
         bcd_q    <= '0;
         upd_q    <= '0;
         sat_q    <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         gch_q    <= gch_d;
         cv_din_q <= cv_din_d;
         bcd_q    <= bcd_d;
         upd_q    <= upd_d;
         sat_q    <= sat_d;
      end
   end

`ifdef CONV_TIMEOUT_EN
   localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

   logic [TW-1:0]  to_cnt_q, to_cnt_d;
   logic [NCH-1:0] err_q, err_d;

   // Give up after TO_CYC cycles in WAIT with no cv_done
   assign to_hit = (state_q == WAIT) && !bus.cv_done && (to_cnt_q == TW'(TO_CYC - 1));

   // Wait-cycle counter cleared on every START; timed-out channel gets its err bit
   always_comb begin
      to_cnt_d = to_cnt_q;
      err_d    = err_q;
      if (state_q == START) begin
         to_cnt_d = '0;
      end else if (state_q == WAIT) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end
      if (to_hit) begin
         for (int k = 0; k < NCH; k++) begin
            if (gch_q == IW'(k)) err_d[k] = 1'b1;
         end
      end
   end

   // Timeout counter and sticky error flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         to_cnt_q <= '0;
         err_q    <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign to_hit  = 1'b0;
   assign bus.err = '0;
`endif

   assign bus.bcd       = bcd_q;
   assign bus.upd       = upd_q;
   assign bus.sat       = sat_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.cv_start  = (state_q == START);
   assign bus.cv_din    = cv_din_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched with a behavioural hex2bcd converter
// (done one cycle after start) that can be switched to a never-done stub.
module tb_bcd_conv_sched;
  import bcd_sched_pkg::*;

  localparam int NCH    = 3;
  localparam int DW     = 7;
  localparam int TO_CYC = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bcd_conv_sched_if #(.NCH(NCH), .DW(DW)) bus ();

  bcd_conv_sched #(.NCH(NCH), .DW(DW), .TO_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- environment drive ----------------
  logic [NCH-1:0]    req_r = '0;
  logic [NCH*DW-1:0] din_r = '0;
  logic              stub_done = 1'b0;
  int                conv_mode = 0;   // 0: real converter, 1: never answers
  logic              cvm_done = 1'b0;
  logic [3:0]        cvm_h = '0;
  logic [3:0]        cvm_l = '0;

  assign bus.req      = req_r;
  assign bus.din      = din_r;
  assign bus.cv_done  = cvm_done | stub_done;
  assign bus.cv_bcd_h = cvm_h;
  assign bus.cv_bcd_l = cvm_l;

  // hex2bcd converter model: answers one cycle after start
  always @(posedge clk) begin
    cvm_done <= 1'b0;
    if (conv_mode == 0 && bus.cv_start === 1'b1) begin
      cvm_done <= 1'b1;
      cvm_h    <= 4'(bus.cv_din / 10);
      cvm_l    <= 4'(bus.cv_din % 10);
    end
  end

  // ---------------- monitor ----------------
  logic [DW-1:0] start_log[$];
  int            upd_cnt[NCH];

  always @(posedge clk) begin
    if (bus.cv_start === 1'b1) start_log.push_back(bus.cv_din);
    for (int k = 0; k < NCH; k++)
      if (bus.upd[k] === 1'b1) upd_cnt[k] <= upd_cnt[k] + 1;
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst   = 1'b0;
    req_r = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse_req(input logic [NCH-1:0] m);
    req_r = m;
    @(negedge clk);
    req_r = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_in_time"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_state(input string name, input state_e s);
    int n;
    n = 0;
    while (bus.state_dbg !== s && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reach_state"}, 32'(bus.state_dbg), 32'(s));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int                ch;
    logic [DW-1:0]     din;
    logic [DW-1:0]     exp_cvdin;
    logic [NCH-1:0]    exp_sat;
    logic [NCH*8-1:0]  exp_bcd;
  } vec_t;

  vec_t vt[7];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, s0, c0, found, n;
    int u0[NCH];
    logic busy_acc, upd_acc;

    vt[0] = '{1, 7'd42,  7'd42, 3'b000, 24'h004200};
    vt[1] = '{0, 7'd120, 7'd99, 3'b001, 24'h004299};
    vt[2] = '{2, 7'd0,   7'd0,  3'b001, 24'h004299};
    vt[3] = '{2, 7'd99,  7'd99, 3'b001, 24'h994299};
    vt[4] = '{1, 7'd7,   7'd7,  3'b001, 24'h990799};
    vt[5] = '{2, 7'd127, 7'd99, 3'b101, 24'h990799};
    vt[6] = '{0, 7'd55,  7'd55, 3'b101, 24'h990755};

    // ---- reset state ----
    do_reset();
    check("rst_bcd",      32'(bus.bcd),       32'd0);
    check("rst_upd",      32'(bus.upd),       32'd0);
    check("rst_sat",      32'(bus.sat),       32'd0);
    check("rst_err",      32'(bus.err),       32'd0);
    check("rst_busy",     32'(bus.busy),      32'd0);
    check("rst_cv_start", 32'(bus.cv_start),  32'd0);
    check("rst_cv_din",   32'(bus.cv_din),    32'd0);
    check("rst_state",    32'(bus.state_dbg), 32'(IDLE));

    // ---- single-channel vectors from idle ----
    for (int i = 0; i < 7; i++) begin
      s0 = start_log.size();
      din_r[vt[i].ch*DW +: DW] = vt[i].din;
      pulse_req(NCH'(1) << vt[i].ch);
      lat = 1;
      while (bus.upd === '0 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_upd", i),     32'(bus.upd), 32'(NCH'(1) << vt[i].ch));
      check($sformatf("v%0d_bcd", i),     32'(bus.bcd), 32'(vt[i].exp_bcd));
      check($sformatf("v%0d_sat", i),     32'(bus.sat), 32'(vt[i].exp_sat));
      @(negedge clk);
      check($sformatf("v%0d_upd_one_cycle", i), 32'(bus.upd), 32'd0);
      check($sformatf("v%0d_start_count", i),   32'(start_log.size() - s0), 32'd1);
      if (start_log.size() > s0)
        check($sformatf("v%0d_cv_din", i), 32'(start_log[s0]), 32'(vt[i].exp_cvdin));
      @(negedge clk);
      check($sformatf("v%0d_idle", i), 32'(bus.busy), 32'd0);
    end

    // ---- simultaneous requests, pointer at 0 after reset ----
    do_reset();
    check("sim_sat_cleared", 32'(bus.sat), 32'd0);
    check("sim_bcd_cleared", 32'(bus.bcd), 32'd0);
    din_r = {7'd56, 7'd34, 7'd12};
    s0 = start_log.size();
    for (int k = 0; k < NCH; k++) u0[k] = upd_cnt[k];
    exp_q.push_back(7'd12);
    exp_q.push_back(7'd34);
    exp_q.push_back(7'd56);
    pulse_req(3'b111);
    wait_idle("sim");
    @(negedge clk);
    check("sim_start_count", 32'(start_log.size() - s0), 32'd3);
    for (int k = 0; k < 3; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      if (start_log.size() > s0 + k)
        check($sformatf("sim_order_%0d", k), 32'(start_log[s0 + k]), 32'(e));
    end
    check("sim_bcd", 32'(bus.bcd), 32'h563412);
    for (int k = 0; k < NCH; k++)
      check($sformatf("sim_upd_cnt_ch%0d", k), 32'(upd_cnt[k] - u0[k]), 32'd1);

    // ---- fairness: ch0 level request, ch2 pulse during ch0 conversion ----
    din_r[0*DW +: DW] = 7'd5;
    din_r[2*DW +: DW] = 7'd88;
    req_r = 3'b001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    req_r = 3'b101;
    @(negedge clk);
    req_r = 3'b001;
    c0 = 0;
    found = 0;
    n = 0;
    while (found == 0 && n < 100) begin
      if (bus.upd[0] === 1'b1) c0++;
      if (bus.upd[2] === 1'b1) found = 1;
      if (found == 0) begin
        @(negedge clk);
        n++;
      end
    end
    check("fair_ch2_served", 32'(found), 32'd1);
    check("fair_ch0_before_ch2_le1", 32'(c0 <= 1), 32'd1);
    req_r = '0;
    wait_idle("fair");
    check("fair_bcd", 32'(bus.bcd), 32'h883405);

    // ---- reset during WAIT, then a late cv_done ----
    do_reset();
    conv_mode = 1;
    din_r[1*DW +: DW] = 7'd33;
    pulse_req(3'b010);
    wait_state("rstw", WAIT);
    pulse_req(3'b100);
    rst = 1'b0;
    @(negedge clk);
    check("rstw_busy_now", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    stub_done = 1'b1;
    @(negedge clk);
    stub_done = 1'b0;
    busy_acc = 1'b0;
    upd_acc  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      busy_acc = busy_acc | bus.busy;
      upd_acc  = upd_acc | (|bus.upd);
      @(negedge clk);
    end
    check("rstw_no_upd",  32'(upd_acc),  32'd0);
    check("rstw_no_busy", 32'(busy_acc), 32'd0);
    check("rstw_bcd",     32'(bus.bcd),  32'd0);

    // ---- converter never answers ----
    din_r[0*DW +: DW] = 7'd21;
    din_r[1*DW +: DW] = 7'd64;
    pulse_req(3'b011);
    wait_state("to", WAIT);
    n = 0;
    din_r[0*DW +: DW] = 7'd77;
    @(negedge clk);
    n++;
    check("to_cv_din_held", 32'(bus.cv_din), 32'd21);
`ifdef CONV_TIMEOUT_EN
    while (bus.err[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_err_ch0",       32'(bus.err), 32'b001);
    check("to_err_latency",   32'(n), 32'(TO_CYC));
    check("to_no_bcd_write",  32'(bus.bcd), 32'd0);
    conv_mode = 0;
    n = 0;
    while (bus.upd === '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_next_upd",      32'(bus.upd), 32'b010);
    check("to_next_bcd",      32'(bus.bcd), 32'h006400);
    check("to_err_sticky",    32'(bus.err), 32'b001);
    wait_idle("to");
`else
    busy_acc = 1'b1;
    upd_acc  = 1'b0;
    for (int k = 0; k < TO_CYC + 16; k++) begin
      busy_acc = busy_acc & bus.busy;
      upd_acc  = upd_acc | (|bus.upd);
      @(negedge clk);
    end
    check("nto_busy_held", 32'(busy_acc), 32'd1);
    check("nto_no_upd",    32'(upd_acc),  32'd0);
    check("nto_err_zero",  32'(bus.err),  32'd0);
    check("nto_state",     32'(bus.state_dbg), 32'(WAIT));
    conv_mode = 0;
    do_reset();
    check("nto_busy_after_rst", 32'(bus.busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
